sonar_scheduler: RTL and testbench

Round-robin scheduler that shares one HC-SR04 measurement unit (trigger generation plus echo-width-to-cm conversion) between the three ultrasonic sensors. It selects a sensor and commands a measurement. It then captures the distance, or flags a timeout, and hands a tagged result word to the serial transmitter. An enforced quiet gap between shots prevents cross-talk between sensors. It sits between the top-level control (ligar) and the shared sonar datapath and TX path.

---
 rtl/sonar_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sonar_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler sharing one HC-SR04 measurement unit between three sensors.
// Each shot: select sensor, command measurement, capture distance or timeout, transmit, quiet gap.
module sonar_scheduler #(
    parameter int GAP_CICLOS     = 3_000_000,
    parameter int TIMEOUT_CICLOS = 1_500_000,
    parameter int DIST_W         = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ligar,
    input  logic              continuo,
    input  logic [2:0]        mascara,
    input  logic              med_pronto,
    input  logic [DIST_W-1:0] med_distancia,
    input  logic              tx_ready,
    output logic              med_medir,
    output logic [1:0]        sel,
    output logic              tx_partida,
    output logic [DIST_W+1:0] tx_dado,
    output logic [2:0]        timeout_flag,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int CNT_MAX = (GAP_CICLOS > TIMEOUT_CICLOS) ? GAP_CICLOS : TIMEOUT_CICLOS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CICLOS - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CICLOS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREPARA   = 3'd1,
        MEDE      = 3'd2,
        ESPERA    = 3'd3,
        ARMAZENA  = 3'd4,
        TRANSMITE = 3'd5,
        AGUARDA   = 3'd6,
        FIM       = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    tcnt_q, tcnt_d;
    logic [CNT_W-1:0]    gcnt_q, gcnt_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic [DIST_W+1:0]   tx_dado_q, tx_dado_d;
    logic [2:0]          tflag_q, tflag_d;

    logic                hit;
    logic [1:0]          hit_idx;

    // Lowest enabled sensor at or above the pointer; pointer value 3 never hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (mascara[i] && (i >= int'(ptr_q))) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        tcnt_d     = tcnt_q;
        gcnt_d     = gcnt_q;
        dist_d     = dist_q;
        tx_dado_d  = tx_dado_q;
        tflag_d    = tflag_q;
        med_medir  = 1'b0;
        tx_partida = 1'b0;
        pronto     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ligar) begin
                    tflag_d = 3'b000;
                    ptr_d   = 2'd0;
                    state_d = PREPARA;
                end
            end
            PREPARA: begin
                if (hit) begin
                    sel_d   = hit_idx;
                    state_d = MEDE;
                end else begin
                    state_d = FIM;
                end
            end
            MEDE: begin
                med_medir = 1'b1;
                tcnt_d    = '0;
                state_d   = ESPERA;
            end
            ESPERA: begin
                // A real echo on the last allowed cycle beats the timeout.
                if (med_pronto) begin
                    dist_d  = med_distancia;
                    state_d = ARMAZENA;
                end else if (tcnt_q == TO_LAST) begin
                    dist_d  = '1;
                    tflag_d = tflag_q | (3'b001 << sel_q);
                    state_d = ARMAZENA;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            ARMAZENA: begin
                tx_dado_d = {sel_q, dist_q};
                state_d   = TRANSMITE;
            end
            TRANSMITE: begin
                if (tx_ready) begin
                    tx_partida = 1'b1;
                    gcnt_d     = '0;
                    state_d    = AGUARDA;
                end
            end
            AGUARDA: begin
                if (gcnt_q == GAP_LAST) begin
                    ptr_d   = sel_q + 2'd1;
                    state_d = PREPARA;
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
            FIM: begin
                pronto = 1'b1;
                if (continuo) begin
                    ptr_d   = 2'd0;
                    state_d = PREPARA;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            tcnt_q    <= '0;
            gcnt_q    <= '0;
            dist_q    <= '0;
            tx_dado_q <= '0;
            tflag_q   <= 3'b000;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            dist_q    <= dist_d;
            tx_dado_q <= tx_dado_d;
            tflag_q   <= tflag_d;
        end
    end

    assign sel          = sel_q;
    assign tx_dado      = tx_dado_q;
    assign timeout_flag = tflag_q;
    assign db_estado    = {1'b0, state_q};

endmodule

// File: tb/tb_sonar_scheduler.sv
// Bench for sonar_scheduler: responder emulates the shared sonar unit, a monitor logs
// transmitted words, and a transaction-level model derives the expected words per sweep.
module tb_sonar_scheduler;

    localparam int GAP = 10;
    localparam int TO  = 50;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        continuo;
    logic [2:0]  mascara;
    logic        med_pronto;
    logic [11:0] med_distancia;
    logic        tx_ready;
    logic        med_medir;
    logic [1:0]  sel;
    logic        tx_partida;
    logic [13:0] tx_dado;
    logic [2:0]  timeout_flag;
    logic        pronto;
    logic [3:0]  db_estado;

    sonar_scheduler #(
        .GAP_CICLOS     (GAP),
        .TIMEOUT_CICLOS (TO),
        .DIST_W         (12)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .continuo      (continuo),
        .mascara       (mascara),
        .med_pronto    (med_pronto),
        .med_distancia (med_distancia),
        .tx_ready      (tx_ready),
        .med_medir     (med_medir),
        .sel           (sel),
        .tx_partida    (tx_partida),
        .tx_dado       (tx_dado),
        .timeout_flag  (timeout_flag),
        .pronto        (pronto),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_fail = 0;
    int          rdelay[3];
    logic [11:0] rdist[3];
    int          pend = 0;
    logic [11:0] pdist = 12'h000;
    bit          rand_ready = 1'b0;
    logic [13:0] got_q[$];
    logic [1:0]  sel_log[$];
    logic [13:0] exp_q[$];
    logic [2:0]  exp_flag;
    int          pronto_cnt = 0;
    int          medir_cnt = 0;
    int          last_tx_cyc = 0;
    bit          gap_arm = 1'b0;
    int          p0, mc0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Shared sonar unit: answers med_medir after rdelay[sel] cycles (0 = never answers).
    initial begin
        forever begin
            @(posedge clock);
            #1;
            med_pronto = 1'b0;
            if (!reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        med_pronto    = 1'b1;
                        med_distancia = pdist;
                    end
                end
                if (med_medir) begin
                    pend  = rdelay[sel];
                    pdist = rdist[sel];
                end
            end
            if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: logs transmissions, shots and sweep ends; checks the quiet gap within a sweep.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                gap_arm = 1'b0;
            end else begin
                if (tx_partida) begin
                    got_q.push_back(tx_dado);
                    last_tx_cyc = cyc;
                    gap_arm     = 1'b1;
                end
                if (med_medir) begin
                    medir_cnt++;
                    sel_log.push_back(sel);
                    if (gap_arm) chk("gap", cyc - last_tx_cyc, GAP + 2);
                    gap_arm = 1'b0;
                end
                if (pronto) begin
                    pronto_cnt++;
                    gap_arm = 1'b0;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic prep_expect(input logic [2:0] m);
        exp_q.delete();
        exp_flag = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (m[i]) begin
                if (rdelay[i] == 0 || rdelay[i] > TO) begin
                    exp_q.push_back({2'(i), 12'hFFF});
                    exp_flag[i] = 1'b1;
                end else begin
                    exp_q.push_back({2'(i), rdist[i]});
                end
            end
        end
    endtask

    task automatic begin_sweep(input logic [2:0] m);
        got_q.delete();
        sel_log.delete();
        p0      = pronto_cnt;
        mc0     = medir_cnt;
        mascara = m;
        ligar   = 1'b1;
        tick();
        ligar   = 1'b0;
    endtask

    task automatic wait_pronto(input int target, input string tag);
        int n = 0;
        while (pronto_cnt < target && n < 4000) begin
            tick();
            n++;
        end
        if (pronto_cnt < target) chk({tag, "_done"}, 32'(pronto_cnt), 32'(target));
    endtask

    task automatic end_sweep(input string tag);
        wait_pronto(p0 + 1, tag);
        chk({tag, "_idle"}, db_estado, 4'd0);
        chk({tag, "_pronto"}, pronto_cnt - p0, 1);
        chk({tag, "_ntx"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_word"}, got_q[i], exp_q[i]);
        chk({tag, "_flag"}, timeout_flag, exp_flag);
        chk({tag, "_nmed"}, medir_cnt - mc0, exp_q.size());
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b0; ligar = 1'b0; continuo = 1'b0; mascara = 3'b000;
        med_pronto = 1'b0; med_distancia = 12'h000; tx_ready = 1'b1;
        rdelay = '{0, 0, 0};
        rdist  = '{12'h000, 12'h000, 12'h000};
        tick(); tick();
        chk("rst_state", db_estado, 4'd0);
        chk("rst_outs", {med_medir, tx_partida, pronto, sel}, 5'b0);
        chk("rst_data", {tx_dado, timeout_flag}, 17'b0);
        reset = 1'b1;
        tick();

        // Full sweep, all sensors answer after 20 cycles.
        rdelay = '{20, 20, 20};
        rdist  = '{12'h100, 12'h074, 12'h075};
        prep_expect(3'b111);
        begin_sweep(3'b111);
        chk("full_prepara", db_estado, 4'd1);
        tick();
        chk("full_medir_lat", {med_medir, sel}, {1'b1, 2'd0});
        end_sweep("full");

        // Empty mask.
        prep_expect(3'b000);
        begin_sweep(3'b000);
        chk("empty_prep", {pronto, db_estado}, {1'b0, 4'd1});
        tick();
        chk("empty_pronto", {pronto, db_estado}, {1'b1, 4'd7});
        end_sweep("empty");

        // Timeout on sensor 1.
        rdelay = '{0, 0, 0};
        prep_expect(3'b010);
        begin_sweep(3'b010);
        n = 0;
        while (!med_medir && n < 20) begin tick(); n++; end
        chk("to_medir_sel", {med_medir, sel}, {1'b1, 2'd1});
        n = 0;
        while (db_estado != 4'd4 && n < 100) begin tick(); n++; end
        chk("to_latency", n, TO + 1);
        chk("to_flag_now", timeout_flag, 3'b010);
        end_sweep("timeout");

        // Reset in ESPERA.
        begin_sweep(3'b100);
        n = 0;
        while (db_estado != 4'd3 && n < 20) begin tick(); n++; end
        chk("rst_in_espera", db_estado, 4'd3);
        repeat (5) tick();
        chk("rst_pre_dado", {sel, tx_dado}, {2'd2, 14'h1FFF});
        reset = 1'b0;
        #1;
        chk("rst_mid_state", db_estado, 4'd0);
        chk("rst_mid_outs", {med_medir, tx_partida, pronto, sel}, 5'b0);
        chk("rst_mid_data", {tx_dado, timeout_flag}, 17'b0);
        tick(); tick();
        reset = 1'b1;
        p0 = pronto_cnt;
        repeat (80) tick();
        chk("rst_no_pronto", pronto_cnt - p0, 0);
        chk("rst_no_tx", got_q.size(), 0);
        chk("rst_idle", db_estado, 4'd0);

        // med_pronto exactly on the timeout cycle.
        rdelay = '{TO, 0, 0};
        rdist  = '{12'h456, 12'h000, 12'h000};
        prep_expect(3'b001);
        begin_sweep(3'b001);
        end_sweep("race");

        // Backpressure: transmitter busy for 100 cycles.
        rdelay = '{20, 0, 0};
        rdist  = '{12'h321, 12'h000, 12'h000};
        tx_ready = 1'b0;
        prep_expect(3'b001);
        begin_sweep(3'b001);
        n = 0;
        while (db_estado != 4'd5 && n < 200) begin tick(); n++; end
        chk("bp_reach", db_estado, 4'd5);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (db_estado !== 4'd5 || tx_partida !== 1'b0 || tx_dado !== 14'h0321) bad++;
            tick();
        end
        chk("bp_hold", bad, 0);
        chk("bp_nopulse", got_q.size(), 0);
        tx_ready = 1'b1;
        #1;
        chk("bp_fire", tx_partida, 1'b1);
        end_sweep("bp");

        // Continuous mode, drop continuo during the third sweep.
        rdelay = '{5, 0, 5};
        rdist  = '{12'h011, 12'h000, 12'h022};
        continuo = 1'b1;
        begin_sweep(3'b101);
        n = 0;
        while (sel_log.size() < 5 && n < 2000) begin tick(); n++; end
        chk("cont_shots_mid", sel_log.size(), 5);
        chk("cont_pronto_mid", pronto_cnt - p0, 2);
        continuo = 1'b0;
        wait_pronto(p0 + 3, "cont");
        chk("cont_idle", db_estado, 4'd0);
        chk("cont_pronto", pronto_cnt - p0, 3);
        chk("cont_nsel", sel_log.size(), 6);
        for (int k = 0; k < sel_log.size(); k++)
            chk("cont_sel", sel_log[k], (k % 2) ? 2'd2 : 2'd0);
        chk("cont_ntx", got_q.size(), 6);
        for (int k = 0; k < got_q.size(); k++)
            chk("cont_word", got_q[k], (k % 2) ? 14'h2022 : 14'h0011);
        mc0 = medir_cnt;
        repeat (40) tick();
        chk("cont_stopped", medir_cnt - mc0, 0);

        // Randomized sweeps with a randomly stalling transmitter.
        rand_ready = 1'b1;
        for (int s = 0; s < 12; s++) begin
            logic [2:0] m;
            m = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0)      rdelay[i] = 0;
                else if (r == 1) rdelay[i] = TO;
                else if (r == 2) rdelay[i] = TO + 1 + $urandom_range(0, 8);
                else             rdelay[i] = $urandom_range(1, TO - 1);
                rdist[i] = 12'($urandom_range(0, 4094));
            end
            prep_expect(m);
            begin_sweep(m);
            end_sweep("rand");
        end
        rand_ready = 1'b0;
        tx_ready   = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
